// File: rtl/svm_pkg.sv
// rtl/svm_pkg.sv - shared types, defaults and helpers for the strided vector memory
package svm_pkg;

   localparam int DEF_LANES    = 8;
   localparam int DEF_PIX_SIZE = 8;
   localparam int DEF_DEPTH    = 36864;
   localparam int DEF_ADDR_W   = 20;
   localparam int DEF_LPC      = 2;

   typedef enum logic [1:0] {IDLE, ACCESS, DRAIN, RESP} state_t;

   typedef logic [DEF_LANES-1:0][DEF_PIX_SIZE-1:0] lane_vec_t;

   function automatic int nb(input int lanes, input int lpc);
      return lanes / lpc;
   endfunction

   function automatic bit lpc_ok(input int lanes, input int lpc);
      return (lpc > 0) && (lanes % lpc == 0);
   endfunction

endpackage

// File: rtl/strided_vector_mem_if.sv
// rtl/strided_vector_mem_if.sv - request/response bus between the vector LSU and the vector memory
interface strided_vector_mem_if #(
   parameter int LANES    = 8,
   parameter int PIX_SIZE = 8,
   parameter int ADDR_W   = 20
);
   logic                      req_valid;
   logic                      req_ready;
   logic                      req_we;
   logic [ADDR_W-1:0]         req_addr;
   logic [ADDR_W-1:0]         req_stride;
   logic [LANES-1:0]          req_mask;
   logic [LANES*PIX_SIZE-1:0] req_wdata;
   logic                      rsp_valid;
   logic                      rsp_ready;
   logic [LANES*PIX_SIZE-1:0] rsp_rdata;
   logic                      rsp_err;
   logic                      busy;

   modport master (
      output req_valid, req_we, req_addr, req_stride, req_mask, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_stride, req_mask, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
   );
endinterface

// File: rtl/svm_addr_gen.sv
// rtl/svm_addr_gen.sv - lane addresses and range flags for one beat of a strided access
module svm_addr_gen
   import svm_pkg::*;
#(
   parameter int LANES  = DEF_LANES,
   parameter int LPC    = DEF_LPC,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int BW     = 2,
   parameter int MEM_AW = 16
) (
   input  logic [ADDR_W-1:0]            base,
   input  logic [ADDR_W-1:0]            stride,
   input  logic [BW-1:0]                beat,
   output logic [LPC-1:0][MEM_AW-1:0]   idx,
   output logic [LPC-1:0]               in_range
);
   // Wide enough that base + (LANES-1)*stride never wraps.
   localparam int EXT_W = ADDR_W + $clog2(LANES) + 1;

   logic [LPC-1:0][EXT_W-1:0] addr;

   always_comb begin
      for (int j = 0; j < LPC; j++) begin
         addr[j]     = EXT_W'(base)
                     + (EXT_W'(beat) * EXT_W'(LPC) + EXT_W'(j)) * EXT_W'(stride);
         in_range[j] = addr[j] < EXT_W'(DEPTH);
         idx[j]      = addr[j][MEM_AW-1:0];
      end
   end

endmodule

// File: rtl/strided_vector_mem.sv
// rtl/strided_vector_mem.sv - gather/scatter vector memory serving LPC lanes per beat
module strided_vector_mem
   import svm_pkg::*;
#(
   parameter int LANES    = DEF_LANES,
   parameter int PIX_SIZE = DEF_PIX_SIZE,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int LPC      = DEF_LPC,
   parameter     INIT_FILE = ""
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   strided_vector_mem_if.slave   bus
);
   localparam int NB     = nb(LANES, LPC);
   localparam int BW     = (NB > 1) ? $clog2(NB) : 1;
   localparam int LW     = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int MEM_AW = $clog2(DEPTH);

   typedef logic [LANES-1:0][PIX_SIZE-1:0] vec_t;

   if (!lpc_ok(LANES, LPC)) begin : g_lpc_check
      $error("strided_vector_mem: LPC must divide LANES");
   end

   state_t                    state, state_n;
   logic [BW-1:0]             beat;
   logic                      we_q;
   logic [ADDR_W-1:0]         base_q, stride_q;
   logic [LANES-1:0]          mask_q;
   vec_t                      wdata_q, rdata_q;
   logic                      err_q, rsp_valid_q;
   logic                      accept, last_beat;
   logic [LPC-1:0][MEM_AW-1:0] idx;
   logic [LPC-1:0]            in_range, lane_en, lane_oor;
   logic [LPC-1:0][LW-1:0]    lane_sel;
   logic [PIX_SIZE-1:0]       mem [DEPTH];

   svm_addr_gen #(
      .LANES(LANES), .LPC(LPC), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .BW(BW), .MEM_AW(MEM_AW)
   ) u_addr_gen (
      .base(base_q), .stride(stride_q), .beat(beat), .idx(idx), .in_range(in_range)
   );

   assign accept    = bus.req_valid && (state == IDLE);
   assign last_beat = (beat == BW'(NB - 1));

   always_comb begin
      for (int j = 0; j < LPC; j++) begin
         lane_sel[j] = LW'(int'(beat) * LPC + j);
         lane_en[j]  = mask_q[lane_sel[j]] && in_range[j];
         lane_oor[j] = mask_q[lane_sel[j]] && !in_range[j];
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (bus.req_valid) state_n = ACCESS;
         ACCESS:  if (last_beat) state_n = we_q ? RESP : DRAIN;
         DRAIN:   state_n = RESP;
         RESP:    if (rsp_valid_q && bus.rsp_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Later lanes overwrite earlier ones on duplicate addresses.
   always_ff @(posedge CLK) begin
      if (state == ACCESS && we_q) begin
         for (int j = 0; j < LPC; j++) begin
            if (lane_en[j]) mem[idx[j]] <= wdata_q[lane_sel[j]];
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state       <= IDLE;
         beat        <= '0;
         we_q        <= 1'b0;
         base_q      <= '0;
         stride_q    <= '0;
         mask_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
      end else begin
         state <= state_n;
         if (accept) begin
            beat     <= '0;
            we_q     <= bus.req_we;
            base_q   <= bus.req_addr;
            stride_q <= bus.req_stride;
            mask_q   <= bus.req_mask;
            wdata_q  <= bus.req_wdata;
            rdata_q  <= '0;
            err_q    <= 1'b0;
         end else if (state == ACCESS) begin
            beat <= beat + 1'b1;
            if (|lane_oor) err_q <= 1'b1;
            if (!we_q) begin
               for (int j = 0; j < LPC; j++) begin
                  if (lane_en[j]) rdata_q[lane_sel[j]] <= mem[idx[j]];
               end
            end
         end
         // Response register goes valid one cycle after entering RESP.
         if (state == RESP && !rsp_valid_q)
            rsp_valid_q <= 1'b1;
         else if (rsp_valid_q && bus.rsp_ready)
            rsp_valid_q <= 1'b0;
      end
   end

   assign bus.req_ready = (state == IDLE);
   assign bus.busy      = (state != IDLE);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_strided_vector_mem.sv
// tb/tb_strided_vector_mem.sv - directed self-checking bench for strided_vector_mem
module tb_strided_vector_mem;
   import svm_pkg::*;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   strided_vector_mem_if bus ();

   strided_vector_mem dut (
      .CLK   (clk),
      .RST_N (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic issue(input logic we, input logic [19:0] addr, input logic [19:0] stride,
                        input logic [7:0] mask, input lane_vec_t wd);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_addr   = addr;
      bus.req_stride = stride;
      bus.req_mask   = mask;
      bus.req_wdata  = wd;
      @(posedge clk);
      #1;
      bus.req_valid  = 1'b0;
   endtask

   task automatic wait_rsp(output int cyc);
      cyc = 0;
      do begin
         @(posedge clk);
         #1;
         cyc++;
      end while (!bus.rsp_valid && cyc < 50);
      total++;
      if (!bus.rsp_valid) begin
         bad++;
         $display("FAIL rsp_timeout rsp_valid=%0b want 1", bus.rsp_valid);
      end
   endtask

   task automatic finish_rsp();
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
   endtask

   task automatic xact(input logic we, input logic [19:0] addr, input logic [19:0] stride,
                       input logic [7:0] mask, input lane_vec_t wd,
                       output int cyc, output lane_vec_t rd, output logic err);
      issue(we, addr, stride, mask, wd);
      wait_rsp(cyc);
      rd  = bus.rsp_rdata;
      err = bus.rsp_err;
      finish_rsp();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total += 5;
      if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got %0b want 1", bus.req_ready); end
      if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got %0b want 0", bus.rsp_valid); end
      if (bus.busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
      if (bus.rsp_err !== 1'b0)   begin bad++; $display("FAIL reset_rsp_err got %0b want 0", bus.rsp_err); end
      if (bus.rsp_rdata !== 64'h0) begin bad++; $display("FAIL reset_rsp_rdata got %h want 0", bus.rsp_rdata); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_gather();
      lane_vec_t wd, exp, rd;
      logic err;
      int cyc;
      for (int i = 0; i < 8; i++) begin
         wd[i]  = 8'(i * 8);
         exp[i] = 8'(i * 8);
      end
      xact(1'b1, 20'd0, 20'd8, 8'hFF, wd, cyc, rd, err);
      total += 3;
      if (cyc !== 5)      begin bad++; $display("FAIL write_latency got %0d want 5", cyc); end
      if (rd !== 64'h0)   begin bad++; $display("FAIL write_rdata got %h want 0", rd); end
      if (err !== 1'b0)   begin bad++; $display("FAIL write_err got %0b want 0", err); end
      issue(1'b0, 20'd0, 20'd8, 8'hFF, '0);
      total++;
      if (bus.busy !== 1'b1) begin bad++; $display("FAIL gather_busy got %0b want 1", bus.busy); end
      wait_rsp(cyc);
      total += 3;
      if (cyc !== 6)              begin bad++; $display("FAIL read_latency got %0d want 6", cyc); end
      if (bus.rsp_rdata !== exp)  begin bad++; $display("FAIL gather_rdata got %h want %h", bus.rsp_rdata, exp); end
      if (bus.rsp_err !== 1'b0)   begin bad++; $display("FAIL gather_err got %0b want 0", bus.rsp_err); end
      finish_rsp();
      total++;
      if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL gather_idle got %0b want 1", bus.req_ready); end
   endtask

   task automatic test_masked_write();
      lane_vec_t wd, exp, rd;
      logic err;
      int cyc;
      for (int i = 0; i < 8; i++) wd[i] = 8'(8'h10 + i);
      xact(1'b1, 20'd100, 20'd1, 8'hFF, wd, cyc, rd, err);
      for (int i = 0; i < 8; i++) begin
         wd[i]  = 8'(8'hA0 + i);
         exp[i] = (i % 2 == 0) ? 8'(8'hA0 + i) : 8'(8'h10 + i);
      end
      xact(1'b1, 20'd100, 20'd1, 8'h55, wd, cyc, rd, err);
      xact(1'b0, 20'd100, 20'd1, 8'hFF, '0, cyc, rd, err);
      total++;
      if (rd !== exp) begin bad++; $display("FAIL masked_write got %h want %h", rd, exp); end
   endtask

   task automatic test_stride0();
      lane_vec_t wd, exp, rd;
      logic err;
      int cyc;
      for (int i = 0; i < 8; i++) wd[i] = 8'(i);
      xact(1'b1, 20'd5, 20'd0, 8'hFF, wd, cyc, rd, err);
      total++;
      if (err !== 1'b0) begin bad++; $display("FAIL stride0_err got %0b want 0", err); end
      exp    = '0;
      exp[0] = 8'd7;
      xact(1'b0, 20'd5, 20'd1, 8'h01, '0, cyc, rd, err);
      total++;
      if (rd !== exp) begin bad++; $display("FAIL stride0_last_wins got %h want %h", rd, exp); end
   endtask

   task automatic test_range();
      lane_vec_t wd, exp, rd;
      logic err;
      int cyc;
      for (int i = 0; i < 8; i++) begin
         wd[i]  = 8'(8'hC0 + i);
         exp[i] = (i < 4) ? 8'(8'hC0 + i) : 8'h00;
      end
      xact(1'b1, 20'd36860, 20'd1, 8'h0F, wd, cyc, rd, err);
      total++;
      if (err !== 1'b0) begin bad++; $display("FAIL range_inbounds_write_err got %0b want 0", err); end
      xact(1'b0, 20'd36860, 20'd1, 8'hFF, '0, cyc, rd, err);
      total += 2;
      if (rd !== exp)   begin bad++; $display("FAIL range_rdata got %h want %h", rd, exp); end
      if (err !== 1'b1) begin bad++; $display("FAIL range_err got %0b want 1", err); end
      xact(1'b0, 20'd0, 20'd8, 8'h01, '0, cyc, rd, err);
      total++;
      if (err !== 1'b0) begin bad++; $display("FAIL range_err_clear got %0b want 0", err); end
   endtask

   task automatic test_backpressure();
      lane_vec_t exp, rd;
      logic err;
      int cyc;
      int bad_hold;
      for (int i = 0; i < 8; i++) exp[i] = 8'(i * 8);
      issue(1'b0, 20'd0, 20'd8, 8'hFF, '0);
      wait_rsp(cyc);
      total++;
      if (bus.rsp_rdata !== exp) begin bad++; $display("FAIL hold_first_rdata got %h want %h", bus.rsp_rdata, exp); end
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b1;
      bus.req_addr   = 20'd0;
      bus.req_stride = 20'd8;
      bus.req_mask   = 8'hFF;
      bus.req_wdata  = {8{8'hEE}};
      bad_hold = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         total += 3;
         if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL hold_rsp_valid c=%0d got %0b want 1", c, bus.rsp_valid); end
         if (bus.rsp_rdata !== exp)  begin bad++; $display("FAIL hold_rdata c=%0d got %h want %h", c, bus.rsp_rdata, exp); end
         if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL hold_req_ready c=%0d got %0b want 0", c, bus.req_ready); end
      end
      bus.req_valid = 1'b0;
      finish_rsp();
      xact(1'b0, 20'd0, 20'd8, 8'hFF, '0, cyc, rd, err);
      total++;
      if (rd !== exp) begin bad++; $display("FAIL hold_ignored_req got %h want %h", rd, exp); end
   endtask

   task automatic test_reset_mid();
      lane_vec_t wd, exp, rd;
      logic err;
      int cyc;
      for (int i = 0; i < 8; i++) wd[i] = 8'(8'h30 + i);
      xact(1'b1, 20'd200, 20'd1, 8'hFF, wd, cyc, rd, err);
      for (int i = 0; i < 8; i++) begin
         wd[i]  = 8'(8'h90 + i);
         exp[i] = (i < 4) ? 8'(8'h90 + i) : 8'(8'h30 + i);
      end
      issue(1'b1, 20'd200, 20'd1, 8'hFF, wd);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      total += 4;
      if (bus.req_ready !== 1'b1)  begin bad++; $display("FAIL midreset_req_ready got %0b want 1", bus.req_ready); end
      if (bus.busy !== 1'b0)       begin bad++; $display("FAIL midreset_busy got %0b want 0", bus.busy); end
      if (bus.rsp_valid !== 1'b0)  begin bad++; $display("FAIL midreset_rsp_valid got %0b want 0", bus.rsp_valid); end
      if (bus.rsp_rdata !== 64'h0) begin bad++; $display("FAIL midreset_rdata got %h want 0", bus.rsp_rdata); end
      @(negedge clk);
      rst_n = 1'b1;
      xact(1'b0, 20'd200, 20'd1, 8'hFF, '0, cyc, rd, err);
      total++;
      if (rd !== exp) begin bad++; $display("FAIL midreset_partial_write got %h want %h", rd, exp); end
   endtask

   initial begin
      total          = 0;
      bad            = 0;
      rst_n          = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_addr   = '0;
      bus.req_stride = '0;
      bus.req_mask   = '0;
      bus.req_wdata  = '0;
      bus.rsp_ready  = 1'b0;
      test_reset();
      test_gather();
      test_masked_write();
      test_stride0();
      test_range();
      test_backpressure();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
